// File: rtl/apb_req_arbiter.sv
// ---------------------------------------------------------------------------
// apb_req_arbiter : two-requester (MDIO/CPU) APB arbiter with ready timeout
// Optional: define APB_ARB_RR_EN for round-robin, else MDIO-first priority
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module apb_req_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [TW-1:0] cfg_timeout,
  input  logic          in_use_mdio,
  input  logic          in_use_cpu,
  input  logic          mdio_psel,
  input  logic          mdio_penable,
  input  logic          mdio_pwrite,
  input  logic [AW-1:0] mdio_paddr,
  input  logic [DW-1:0] mdio_pwdata,
  output logic          mdio_pready,
  output logic          mdio_pslverr,
  output logic [DW-1:0] mdio_prdata,
  input  logic          cpu_psel,
  input  logic          cpu_penable,
  input  logic          cpu_pwrite,
  input  logic [AW-1:0] cpu_paddr,
  input  logic [DW-1:0] cpu_pwdata,
  output logic          cpu_pready,
  output logic          cpu_pslverr,
  output logic [DW-1:0] cpu_prdata,
  output logic          m_psel,
  output logic          m_penable,
  output logic          m_pwrite,
  output logic [AW-1:0] m_paddr,
  output logic [DW-1:0] m_pwdata,
  input  logic [DW-1:0] m_prdata,
  input  logic          m_pready,
  input  logic          m_pslverr,
  output logic          busy,
  output logic          timeout_pulse
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam logic MDIO = 1'b0;
  localparam logic CPU  = 1'b1;

  logic [1:0]    state;
  // last_grant doubles as the current grantee while a transfer is in flight
  logic          last_grant;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          write;
  logic [DW-1:0] rdata;
  logic          slverr;
  logic [TW-1:0] cnt;
  logic          pulse;

  logic          mdio_valid;
  logic          cpu_valid;
  logic          pick;
  logic [TW-1:0] cnt_inc;
  logic          expire;
  logic          grantee_penable;
  logic          in_xfer;

  assign mdio_valid = mdio_psel & in_use_mdio;
  assign cpu_valid  = cpu_psel & in_use_cpu;

  always_comb begin
    pick = CPU;
`ifdef APB_ARB_RR_EN
    if (mdio_valid && cpu_valid) pick = ~last_grant;
    else if (mdio_valid)         pick = MDIO;
`else
    if (mdio_valid)              pick = MDIO;
`endif
  end

  assign cnt_inc         = (cnt == {TW{1'b1}}) ? cnt : cnt + TW'(1);
  assign expire          = (cfg_timeout != '0) && (cnt_inc >= cfg_timeout);
  assign grantee_penable = (last_grant == CPU) ? cpu_penable : mdio_penable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= CPU;
      addr       <= '0;
      wdata      <= '0;
      write      <= 1'b0;
      rdata      <= '0;
      slverr     <= 1'b0;
      cnt        <= '0;
      pulse      <= 1'b0;
    end else begin
      pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (mdio_valid || cpu_valid) begin
            last_grant <= pick;
            addr       <= (pick == CPU) ? cpu_paddr  : mdio_paddr;
            wdata      <= (pick == CPU) ? cpu_pwdata : mdio_pwdata;
            write      <= (pick == CPU) ? cpu_pwrite : mdio_pwrite;
            state      <= SETUP;
          end
        end
        SETUP: begin
          cnt   <= '0;
          state <= ACCESS;
        end
        ACCESS: begin
          if (m_pready) begin
            rdata  <= write ? '0 : m_prdata;
            slverr <= m_pslverr;
            state  <= RESP;
          end else begin
            cnt <= cnt_inc;
            if (expire) begin
              rdata  <= '0;
              slverr <= 1'b1;
              pulse  <= 1'b1;
              state  <= RESP;
            end
          end
        end
        RESP: begin
          if (grantee_penable) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_xfer       = (state == SETUP) || (state == ACCESS);
  assign m_psel        = in_xfer;
  assign m_penable     = (state == ACCESS);
  assign m_paddr       = in_xfer ? addr  : '0;
  assign m_pwdata      = in_xfer ? wdata : '0;
  assign m_pwrite      = in_xfer & write;
  assign busy          = (state != IDLE);
  assign timeout_pulse = pulse;

  // A requester disabled at grant time keeps its transfer; the error reply
  // only applies to requesters that do not own the downstream port.
  always_comb begin
    mdio_pready  = 1'b0;
    mdio_pslverr = 1'b0;
    mdio_prdata  = '0;
    if (state == RESP && last_grant == MDIO && mdio_penable) begin
      mdio_pready  = 1'b1;
      mdio_pslverr = slverr;
      mdio_prdata  = rdata;
    end else if (!(busy && last_grant == MDIO) && mdio_psel && mdio_penable && !in_use_mdio) begin
      mdio_pready  = 1'b1;
      mdio_pslverr = 1'b1;
    end
  end

  always_comb begin
    cpu_pready  = 1'b0;
    cpu_pslverr = 1'b0;
    cpu_prdata  = '0;
    if (state == RESP && last_grant == CPU && cpu_penable) begin
      cpu_pready  = 1'b1;
      cpu_pslverr = slverr;
      cpu_prdata  = rdata;
    end else if (!(busy && last_grant == CPU) && cpu_psel && cpu_penable && !in_use_cpu) begin
      cpu_pready  = 1'b1;
      cpu_pslverr = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_apb_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_req_arbiter : randomized self-checking bench for apb_req_arbiter
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_apb_req_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TW = 16;
`ifdef APB_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [TW-1:0] cfg_timeout;
  logic          in_use_mdio, in_use_cpu;
  logic          mdio_psel, mdio_penable, mdio_pwrite;
  logic [AW-1:0] mdio_paddr;
  logic [DW-1:0] mdio_pwdata, mdio_prdata;
  logic          mdio_pready, mdio_pslverr;
  logic          cpu_psel, cpu_penable, cpu_pwrite;
  logic [AW-1:0] cpu_paddr;
  logic [DW-1:0] cpu_pwdata, cpu_prdata;
  logic          cpu_pready, cpu_pslverr;
  logic          m_psel, m_penable, m_pwrite;
  logic [AW-1:0] m_paddr;
  logic [DW-1:0] m_pwdata, m_prdata;
  logic          m_pready, m_pslverr;
  logic          busy, timeout_pulse;

  apb_req_arbiter #(.AW(AW), .DW(DW), .TW(TW)) dut (
    .clk(clk), .rst(rst), .cfg_timeout(cfg_timeout),
    .in_use_mdio(in_use_mdio), .in_use_cpu(in_use_cpu),
    .mdio_psel(mdio_psel), .mdio_penable(mdio_penable), .mdio_pwrite(mdio_pwrite),
    .mdio_paddr(mdio_paddr), .mdio_pwdata(mdio_pwdata), .mdio_pready(mdio_pready),
    .mdio_pslverr(mdio_pslverr), .mdio_prdata(mdio_prdata),
    .cpu_psel(cpu_psel), .cpu_penable(cpu_penable), .cpu_pwrite(cpu_pwrite),
    .cpu_paddr(cpu_paddr), .cpu_pwdata(cpu_pwdata), .cpu_pready(cpu_pready),
    .cpu_pslverr(cpu_pslverr), .cpu_prdata(cpu_prdata),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_prdata(m_prdata),
    .m_pready(m_pready), .m_pslverr(m_pslverr),
    .busy(busy), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0;
  int nbad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Downstream slave model: ready after dn_wait ACCESS cycles, logs transfers.
  int            dn_wait = 0;
  logic [DW-1:0] dn_data = '0;
  logic          dn_err  = 1'b0;
  int            acc_k = 0, pen_cycles = 0, sel_cycles = 0, pulses = 0, unstable = 0;
  logic [AW-1:0] q_addr[$];
  logic [DW-1:0] q_wdata[$];
  logic          q_wr[$];

  initial begin
    m_pready = 1'b0; m_prdata = '0; m_pslverr = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (m_psel) sel_cycles++;
      if (timeout_pulse) pulses++;
      if (m_psel && m_penable) begin
        if (acc_k == 0) begin
          q_addr.push_back(m_paddr); q_wdata.push_back(m_pwdata); q_wr.push_back(m_pwrite);
        end else if (m_paddr !== q_addr[$] || m_pwdata !== q_wdata[$] || m_pwrite !== q_wr[$]) begin
          unstable++;
        end
        m_pready  = (acc_k == dn_wait);
        m_prdata  = dn_data;
        m_pslverr = dn_err;
        acc_k++;
        pen_cycles++;
      end else begin
        m_pready = 1'b0; m_prdata = '0; m_pslverr = 1'b0; acc_k = 0;
      end
    end
  end

  task automatic drive(input int who, input logic sel, input logic pen, input logic wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (who == 0) begin
      mdio_psel = sel; mdio_penable = pen; mdio_pwrite = wr; mdio_paddr = a; mdio_pwdata = d;
    end else begin
      cpu_psel = sel; cpu_penable = pen; cpu_pwrite = wr; cpu_paddr = a; cpu_pwdata = d;
    end
  endtask

  // Called 1 time unit after a rising edge; returns aligned the same way.
  task automatic do_xfer(input int who, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output int lat,
                         output logic [DW-1:0] rd, output logic err);
    int start;
    bit done;
    logic rdy;
    done = 1'b0; lat = -1; rd = '0; err = 1'b0;
    drive(who, 1'b1, 1'b0, wr, a, d);
    start = cyc;
    @(posedge clk); #1;
    drive(who, 1'b1, 1'b1, wr, a, d);
    for (int i = 0; i < 3000 && !done; i++) begin
      #1;
      rdy = (who == 0) ? mdio_pready : cpu_pready;
      if (rdy) begin
        rd   = (who == 0) ? mdio_prdata  : cpu_prdata;
        err  = (who == 0) ? mdio_pslverr : cpu_pslverr;
        lat  = cyc - start;
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    drive(who, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // Reference: downstream ACCESS cycles and reply of one granted transfer.
  bit model_last = 1'b1;

  function automatic void model(input logic wr, input int w, input int n, input logic [DW-1:0] dd,
                                input logic de, output int dur, output logic [DW-1:0] rd,
                                output logic err, output bit to);
    to  = (n != 0) && (w >= n);
    dur = to ? n : w + 1;
    rd  = (to || wr) ? '0 : dd;
    err = to ? 1'b1 : de;
  endfunction

  // mode: 0 MDIO only, 1 CPU only, 2 both together, 3 disabled MDIO
  task automatic run(input int mode, input int w, input int n, input logic wr0, input logic wr1,
                     input logic [DW-1:0] dd, input logic de);
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1, rd0, rd1, erd_w, erd_l;
    logic          err0, err1, eerr_w, eerr_l;
    int            lat0, lat1, p0, e0, s0, win, nx, dur;
    bit            to;
    a0 = $urandom; a1 = $urandom; d0 = $urandom; d1 = $urandom;
    dn_wait = w; dn_data = dd; dn_err = de;
    cfg_timeout = n[TW-1:0];
    in_use_mdio = (mode != 3); in_use_cpu = 1'b1;
    q_addr.delete(); q_wdata.delete(); q_wr.delete();
    p0 = pulses; e0 = pen_cycles; s0 = sel_cycles; unstable = 0;
    lat0 = -1; lat1 = -1; rd0 = '0; rd1 = '0; err0 = 1'b0; err1 = 1'b0;
    case (mode)
      0, 3: do_xfer(0, wr0, a0, d0, lat0, rd0, err0);
      1:    do_xfer(1, wr1, a1, d1, lat1, rd1, err1);
      default: fork
        do_xfer(0, wr0, a0, d0, lat0, rd0, err0);
        do_xfer(1, wr1, a1, d1, lat1, rd1, err1);
      join
    endcase
    if (mode == 3) begin
      chk("dis_lat", lat0, 1);
      chk("dis_err", err0, 1);
      chk("dis_rdata", rd0, 0);
      chk("dis_msel", sel_cycles - s0, 0);
    end else begin
      if (mode == 2) win = RR ? (model_last ? 0 : 1) : 0;
      else           win = mode;
      nx = (mode == 2) ? 2 : 1;
      model(win ? wr1 : wr0, w, n, dd, de, dur, erd_w, eerr_w, to);
      chk("win_lat", win ? lat1 : lat0, 2 + dur);
      chk("win_rdata", win ? rd1 : rd0, erd_w);
      chk("win_err", win ? err1 : err0, eerr_w);
      chk("q_size", q_addr.size(), nx);
      if (q_addr.size() >= 1) begin
        chk("win_addr", q_addr[0], win ? a1 : a0);
        chk("win_wdata", q_wdata[0], win ? d1 : d0);
        chk("win_wr", q_wr[0], win ? wr1 : wr0);
      end
      model_last = win[0];
      if (mode == 2) begin
        model(win ? wr0 : wr1, w, n, dd, de, dur, erd_l, eerr_l, to);
        chk("los_lat", win ? lat0 : lat1, 5 + 2 * dur);
        chk("los_rdata", win ? rd0 : rd1, erd_l);
        chk("los_err", win ? err0 : err1, eerr_l);
        if (q_addr.size() >= 2) chk("los_addr", q_addr[1], win ? a0 : a1);
        model_last = ~win[0];
      end
      chk("pulses", pulses - p0, to ? nx : 0);
      chk("pen_cycles", pen_cycles - e0, dur * nx);
      chk("stable", unstable, 0);
    end
    chk("idle_busy", busy, 0);
    chk("idle_addr", m_paddr, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] rd;
    logic          err;
    int            lat;
    rst = 1'b1; cfg_timeout = '0; in_use_mdio = 1'b1; in_use_cpu = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_msel", {m_psel, m_penable, m_pwrite, busy, timeout_pulse}, 0);
    chk("rst_up", {mdio_pready, mdio_pslverr, cpu_pready, cpu_pslverr}, 0);
    chk("rst_data", {m_paddr, m_pwdata}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    run(1, 0, 0, 1'b0, 1'b0, 32'hA5A5_0001, 1'b0);
    run(3, 0, 0, 1'b1, 1'b0, 32'h0, 1'b0);
    run(2, 0, 0, 1'b0, 1'b1, 32'h1234_5678, 1'b0);
    run(2, 0, 0, 1'b1, 1'b0, 32'h8765_4321, 1'b0);
    run(1, 100000, 5, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    run(0, 1000, 0, 1'b0, 1'b0, 32'h0BAD_F00D, 1'b0);
    run(0, 4, 5, 1'b0, 1'b0, 32'hCAFE_0005, 1'b0);

    // Reset during ACCESS, then a clean CPU read
    dn_wait = 1000; cfg_timeout = '0;
    drive(1, 1'b1, 1'b0, 1'b0, 32'h40, '0);
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b1, 1'b0, 32'h40, '0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("midrst_m", {m_psel, m_penable, busy, timeout_pulse}, 0);
    chk("midrst_up", {cpu_pready, cpu_pslverr, cpu_prdata, m_paddr}, 0);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
    rst = 1'b0;
    model_last = 1'b1;
    @(posedge clk); #1;
    dn_wait = 0; dn_data = 32'h5A5A_0002; dn_err = 1'b0;
    do_xfer(1, 1'b0, 32'h44, '0, lat, rd, err);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_rdata", rd, 32'h5A5A_0002);
    chk("post_rst_err", err, 0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      int mode, w, n;
      mode = $urandom_range(0, 3);
      w    = $urandom_range(0, 6);
      n    = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 6);
      run(mode, w, n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nbad);
    $finish;
  end

endmodule

`default_nettype wire
